pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards, tracks data-cache miss waits and taken-branch flushes.
- Drives PC, IF/ID and ID/EX register controls, plus the CacheStall_i input of every pipeline register.
- Keeps a saturating stall-cycle counter and a cache-timeout watchdog.

Parameters:
- CNT_W, 16, width of the stall-cycle performance counter.
- MAX_WAIT, 64, maximum cycles in cache wait before a timeout error. Must be at least 2.

Ports:
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RtAddr_i  in  5  destination register of that load.
- IFID_RsAddr_i  in  5  rs of the instruction in ID.
- IFID_RtAddr_i  in  5  rt of the instruction in ID.
- Branch_taken_i  in  1  branch/jump resolved taken in ID.
- DCache_req_i  in  1  MEM stage issues a data-cache access this cycle.
- DCache_ack_i  in  1  data cache completes the access this cycle.
- PC_Write_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register write enable.
- IFID_Flush_o  out  1  zero the IF/ID instruction (squash).
- IDEX_Bubble_o  out  1  zero the WB/MEM/EX control fields into ID/EX.
- CacheStall_o  out  1  freeze all pipeline registers.
- StallCnt_o  out  CNT_W  number of cycles with PC_Write_o=0; saturates.
- Err_o  out  1  sticky cache-timeout flag.

Behaviour:
- FSM states: RUN, CACHE_WAIT, ERR. Reset enters RUN.
- State, wait counter, StallCnt_o and Err_o are registered. Every other output is combinational from state and inputs, with zero latency.
- While rst_i=0, all outputs are forced to 0. This includes PC_Write_o and IFID_Write_o.
- miss = DCache_req_i & ~DCache_ack_i.
- lu = IDEX_MemRead_i & (IDEX_RtAddr_i≠0) & (IDEX_RtAddr_i==IFID_RsAddr_i | IDEX_RtAddr_i==IFID_RtAddr_i).
- RUN outputs:
  - CacheStall_o = miss.
  - If miss: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0, IFID_Flush_o=0. The cache stall has top priority and the pipeline is frozen, not bubbled.
  - Else if lu: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0. The branch is re-evaluated next cycle.
  - Else: PC_Write_o=1, IFID_Write_o=1, IDEX_Bubble_o=0, IFID_Flush_o=Branch_taken_i.
- RUN transitions: miss goes to CACHE_WAIT with wait_cnt cleared to 1. Otherwise stay in RUN.
- CACHE_WAIT outputs:
  - CacheStall_o = ~DCache_ack_i.
  - PC_Write_o=0 and IFID_Write_o=0 while stalled.
  - On the ack cycle, outputs equal the RUN no-miss evaluation, so lu and branch decisions are taken in the same cycle.
- CACHE_WAIT transitions:
  - DCache_ack_i goes to RUN.
  - Else if wait_cnt==MAX_WAIT-1, go to ERR.
  - Else wait_cnt+1.
  - Ack wins over timeout in the same cycle.
- ERR: CacheStall_o=1, PC_Write_o=0, IFID_Write_o=0, Err_o=1 (sticky). Only reset leaves this state.
- StallCnt_o increments on every posedge where PC_Write_o=0 (any cause, including ERR). It holds at all-ones and does not wrap.
- Reset asserted mid-wait:
  - Immediate return to RUN.
  - Counters and Err_o cleared.
  - Outputs forced to 0 asynchronously.
- Cache control flow is assumed absent: DCache_req_i low with DCache_ack_i high in RUN is ignored.

Decomposition:
- pipe_ctrl_pkg holds:
  - the state enum (RUN, CACHE_WAIT, ERR);
  - REG_ZERO = 5'd0;
  - the default CNT_W and MAX_WAIT values.
- One combinational sub-module, hazard_detect, computes lu from IDEX_MemRead/IDEX_RtAddr/IFID_RsAddr/IFID_RtAddr. It is reused by the future branch-compare forwarding unit.

Test Plan:
- Load-use: MemRead=1, IDEX_Rt=8, IFID_Rs=8 in RUN.
  - Required: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly 1 cycle, then all-run.
  - StallCnt goes 0→1.
- No false hazard: IDEX_Rt=0 and IFID_Rs=0 with MemRead=1 → PC_Write=1, Bubble=0. IDEX_Rt=9 with IFID_Rs=8, IFID_Rt=10 → no stall.
- Cache miss of 3 cycles: req=1, ack=0 for 3 cycles, then ack=1.
  - Required: CacheStall=1 for 3 cycles, 0 on the ack cycle.
  - State returns to RUN and StallCnt increases by 3.
  - A lu present on the ack cycle yields Bubble=1 in that cycle.
- Branch versus stalls:
  - Branch_taken=1 alone → IFID_Flush=1, PC_Write=1.
  - Branch_taken=1 with lu → Flush=0, Bubble=1.
  - Branch_taken=1 with miss → Flush=0, CacheStall=1.
- Timeout with MAX_WAIT=4: req=1 and ack never asserted → Err=1 after 4 stall cycles, CacheStall stuck at 1. A later ack has no effect. rst_i=0 clears Err, StallCnt and state.
- Saturation with CNT_W=4: hold a miss to timeout, stay in ERR for 20 cycles → StallCnt=15 and held. Also pulse rst_i low mid-CACHE_WAIT → outputs go to 0 immediately and the FSM restarts in RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      CACHE_WAIT = 2'd1,
      ERR        = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int unsigned CNT_W_DEF    = 16;
   localparam int unsigned MAX_WAIT_DEF = 64;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register read by the
// instruction in ID. $zero never creates a hazard.
// Ports:
//   IDEX_MemRead_i - EX instruction is a load
//   IDEX_RtAddr_i  - load destination register
//   IFID_RsAddr_i  - rs of the ID instruction
//   IFID_RtAddr_i  - rt of the ID instruction
//   lu_o           - load-use hazard (combinational)
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       IDEX_MemRead_i,
   input  logic [4:0] IDEX_RtAddr_i,
   input  logic [4:0] IFID_RsAddr_i,
   input  logic [4:0] IFID_RtAddr_i,
   output logic       lu_o
);

   assign lu_o = IDEX_MemRead_i
               & (IDEX_RtAddr_i != REG_ZERO)
               & ((IDEX_RtAddr_i == IFID_RsAddr_i) | (IDEX_RtAddr_i == IFID_RtAddr_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-low reset
//   IDEX_*/IFID_*      - register addresses for load-use detection
//   Branch_taken_i     - branch resolved taken in ID
//   DCache_req_i/ack_i - data-cache access request / completion
//   PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, CacheStall_o
//                      - pipeline controls, combinational from state+inputs
//   StallCnt_o         - saturating count of cycles with PC_Write_o low
//   Err_o              - sticky cache-timeout flag
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_RtAddr_i,
   input  logic [4:0]       IFID_RsAddr_i,
   input  logic [4:0]       IFID_RtAddr_i,
   input  logic             Branch_taken_i,
   input  logic             DCache_req_i,
   input  logic             DCache_ack_i,
   output logic             PC_Write_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             CacheStall_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic             Err_o
);

   // wait_cnt never exceeds MAX_WAIT-1
   localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                lu;
   logic                miss;

   hazard_detect u_hazard_detect (
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_RtAddr_i  (IDEX_RtAddr_i),
      .IFID_RsAddr_i  (IFID_RsAddr_i),
      .IFID_RtAddr_i  (IFID_RtAddr_i),
      .lu_o           (lu)
   );

   assign miss = DCache_req_i & ~DCache_ack_i;

   // Next state and pipeline controls; the ack cycle of a wait reuses the
   // no-miss RUN decision so load-use and branch resolve without delay.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      PC_Write_o    = 1'b0;
      IFID_Write_o  = 1'b0;
      IFID_Flush_o  = 1'b0;
      IDEX_Bubble_o = 1'b0;
      CacheStall_o  = 1'b0;

      unique case (state_q)
         RUN: begin
            if (miss) begin
               CacheStall_o = 1'b1;
               state_d      = CACHE_WAIT;
               wait_cnt_d   = WAIT_W'(1);
            end else if (lu) begin
               IDEX_Bubble_o = 1'b1;
            end else begin
               PC_Write_o   = 1'b1;
               IFID_Write_o = 1'b1;
               IFID_Flush_o = Branch_taken_i;
            end
         end
         CACHE_WAIT: begin
            if (DCache_ack_i) begin
               state_d = RUN;
               if (lu) begin
                  IDEX_Bubble_o = 1'b1;
               end else begin
                  PC_Write_o   = 1'b1;
                  IFID_Write_o = 1'b1;
                  IFID_Flush_o = Branch_taken_i;
               end
            end else begin
               CacheStall_o = 1'b1;
               if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                  state_d = ERR;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         ERR: begin
            CacheStall_o = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // Reset overrides every control output, including the write enables
      if (!rst_i) begin
         PC_Write_o    = 1'b0;
         IFID_Write_o  = 1'b0;
         IFID_Flush_o  = 1'b0;
         IDEX_Bubble_o = 1'b0;
         CacheStall_o  = 1'b0;
      end
   end

   // State, wait counter, saturating stall counter and sticky error
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         StallCnt_o <= '0;
         Err_o      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!PC_Write_o && (StallCnt_o != {CNT_W{1'b1}})) begin
            StallCnt_o <= StallCnt_o + CNT_W'(1);
         end
         if (state_d == ERR) begin
            Err_o <= 1'b1;
         end
      end
   end

endmodule
